// File: rtl/hqm_AW_pkg.sv
// Shared helpers for the hqm_AW_* arithmetic/encode blocks.
package hqm_AW_pkg;

   // floor(log2(value)); returns 0 for value <= 1.
   function automatic int AW_logb2(input int value);
      int r;
      r = 0;
      for (int i = 1; i < 31; i++) begin
         if ((value >> i) != 0) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/hqm_aw_leading_zeros_if.sv
// Bus bundle for the leading-zero encoder: scanned vector in, markers/counts out.
interface hqm_aw_leading_zeros_if #(
   parameter int WIDTH = 16
) ();
   import hqm_AW_pkg::*;

   localparam int EWIDTH = AW_logb2(WIDTH-1) + 2;

   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  dec;
   logic [EWIDTH-1:0] enc;
   logic              any;
   logic [EWIDTH-1:0] enc_q;
   logic [WIDTH-1:0]  dec_q;
   logic              any_q;

   modport master (
      output a,
      input  dec, enc, any, enc_q, dec_q, any_q
   );

   modport slave (
      input  a,
      output dec, enc, any, enc_q, dec_q, any_q
   );
endinterface

// File: rtl/hqm_AW_lz_node.sv
// One merge node of the leading-zero tree: combines an upper and a lower half of HW bits each.
module hqm_AW_lz_node #(
   parameter int HW = 1,
   parameter int CW = 2
) (
   input  logic [CW-1:0] left_cnt,
   input  logic          left_zero,
   input  logic [CW-1:0] right_cnt,
   input  logic          right_zero,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   // An all-zero upper half contributes its full size, then the lower half keeps counting.
   assign cnt  = left_zero ? (CW'(HW) + right_cnt) : left_cnt;
   assign zero = left_zero & right_zero;

endmodule

// File: rtl/hqm_aw_leading_zeros.sv
// Leading-zero count with one-hot MSB marker, combinational and registered copies.
module hqm_aw_leading_zeros
   import hqm_AW_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   hqm_aw_leading_zeros_if.slave lz
);

   localparam int EWIDTH = AW_logb2(WIDTH-1) + 2;
   localparam int LEVELS = $clog2(WIDTH);
   localparam int PWIDTH = 1 << LEVELS;
   localparam int CW     = LEVELS + 1;
   localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

   logic [PWIDTH-1:0] a_pad;
   logic [CW-1:0]     cnt_h  [1:2*PWIDTH-1];
   logic              zero_h [1:2*PWIDTH-1];
   logic [EWIDTH-1:0] enc_c;
   logic              any_c;

   // Zero padding sits below the real bits so it can only add to an all-zero count.
   always_comb begin
      a_pad = '0;
      a_pad[PWIDTH-1 -: WIDTH] = lz.a;
   end

   // Heap layout: node n has upper child 2n and lower child 2n+1; leaf PWIDTH+k holds bit PWIDTH-1-k.
   genvar gi;
   generate
      for (gi = 0; gi < PWIDTH; gi++) begin : g_leaf
         assign zero_h[PWIDTH+gi] = ~a_pad[PWIDTH-1-gi];
         assign cnt_h[PWIDTH+gi]  = {{(CW-1){1'b0}}, ~a_pad[PWIDTH-1-gi]};
      end

      for (gi = 1; gi < PWIDTH; gi++) begin : g_node
         hqm_AW_lz_node #(
            .HW (PWIDTH >> (AW_logb2(gi) + 1)),
            .CW (CW)
         ) u_node (
            .left_cnt   (cnt_h[2*gi]),
            .left_zero  (zero_h[2*gi]),
            .right_cnt  (cnt_h[2*gi+1]),
            .right_zero (zero_h[2*gi+1]),
            .cnt        (cnt_h[gi]),
            .zero       (zero_h[gi])
         );
      end
   endgenerate

   // An all-zero input counts through the padding too, so clamp it back to WIDTH.
   assign any_c  = ~zero_h[1];
   assign enc_c  = zero_h[1] ? EWIDTH'(WIDTH) : EWIDTH'(cnt_h[1]);
   assign lz.enc = enc_c;
   assign lz.any = any_c;
   assign lz.dec = any_c ? (MSB_ONE >> enc_c) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lz.enc_q <= EWIDTH'(WIDTH);
         lz.dec_q <= '0;
         lz.any_q <= 1'b0;
      end else begin
         lz.enc_q <= enc_c;
         lz.dec_q <= lz.dec;
         lz.any_q <= any_c;
      end
   end

endmodule

// File: tb/tb_hqm_aw_leading_zeros.sv
// Self-checking bench: directed and random checks of hqm_aw_leading_zeros at WIDTH 2, 4, 16, 1024.
module tb_hqm_aw_leading_zeros;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hqm_aw_leading_zeros_if #(.WIDTH(2))    if2 ();
   hqm_aw_leading_zeros_if #(.WIDTH(4))    if4 ();
   hqm_aw_leading_zeros_if #(.WIDTH(16))   if16 ();
   hqm_aw_leading_zeros_if #(.WIDTH(1024)) if1k ();

   hqm_aw_leading_zeros #(.WIDTH(2))    u_dut2  (.clk(clk), .rst(rst), .lz(if2));
   hqm_aw_leading_zeros #(.WIDTH(4))    u_dut4  (.clk(clk), .rst(rst), .lz(if4));
   hqm_aw_leading_zeros #(.WIDTH(16))   u_dut16 (.clk(clk), .rst(rst), .lz(if16));
   hqm_aw_leading_zeros #(.WIDTH(1024)) u_dut1k (.clk(clk), .rst(rst), .lz(if1k));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scan from the top bit down to the first 1.
   function automatic int ref_lz(input logic [1023:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) begin
         if (v[i]) return w - 1 - i;
      end
      return w;
   endfunction

   function automatic logic [1023:0] ref_dec(input logic [1023:0] v, input int w);
      logic [1023:0] d;
      int            n;
      d = '0;
      n = ref_lz(v, w);
      if (n < w) d[w-1-n] = 1'b1;
      return d;
   endfunction

   function automatic int msb_idx(input logic [1023:0] v);
      for (int i = 1023; i >= 0; i--) begin
         if (v[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed msb=%0d ones=%0d required msb=%0d ones=%0d",
                tag, msb_idx(obs), $countones(obs), msb_idx(exp), $countones(exp));
      end
   endtask

   logic [15:0] tv16 [5] = '{16'h8000, 16'h0001, 16'h0000, 16'h00F0, 16'h7FFF};
   int          te16 [5] = '{0, 15, 16, 8, 1};
   logic [15:0] td16 [5] = '{16'h8000, 16'h0001, 16'h0000, 16'h0080, 16'h4000};
   int          te2  [4] = '{2, 1, 0, 0};
   logic [1:0]  td2  [4] = '{2'b00, 2'b01, 2'b10, 2'b10};

   logic [3:0]    r4;
   logic [15:0]   r16;
   logic [1023:0] r1k;
   int            n4, n16, n1k;
   logic [1023:0] d4, d16, d1k;

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      if2.a  = '0;
      if4.a  = '0;
      if16.a = 16'h0400;
      if1k.a = '0;

      // Reset held: registers show the all-zero result while the comb path follows a.
      #1;
      chk("rst_enc_q", 64'(if16.enc_q), 64'd16);
      chk("rst_dec_q", 64'(if16.dec_q), 64'h0);
      chk("rst_any_q", 64'(if16.any_q), 64'd0);
      chk("rst_enc_comb", 64'(if16.enc), 64'd5);
      chk("rst_any_comb", 64'(if16.any), 64'd1);
      @(posedge clk); #1;
      chk("rst_hold_enc_q", 64'(if16.enc_q), 64'd16);
      chk("rst_hold_dec_q", 64'(if16.dec_q), 64'h0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_enc_q", 64'(if16.enc_q), 64'd5);
      chk("post_rst_dec_q", 64'(if16.dec_q), 64'h0400);
      chk("post_rst_any_q", 64'(if16.any_q), 64'd1);

      // Directed WIDTH=16 patterns.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk) if16.a = tv16[i];
         #1;
         $display("w16 a=%h enc=%0d dec=%h any=%0d", if16.a, if16.enc, if16.dec, if16.any);
         chk("w16_enc", 64'(if16.enc), 64'(te16[i]));
         chk("w16_dec", 64'(if16.dec), 64'(td16[i]));
         chk("w16_any", 64'(if16.any), (te16[i] != 16) ? 64'd1 : 64'd0);
      end

      // WIDTH=2 exhaustive.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) if2.a = 2'(i);
         #1;
         $display("w2 a=%b enc=%0d dec=%b any=%0d", if2.a, if2.enc, if2.dec, if2.any);
         chk("w2_enc", 64'(if2.enc), 64'(te2[i]));
         chk("w2_dec", 64'(if2.dec), 64'(td2[i]));
         chk("w2_any", 64'(if2.any), (te2[i] != 2) ? 64'd1 : 64'd0);
      end

      // Reset asserted between edges must clear the registers at once.
      @(negedge clk) if16.a = 16'h0010;
      @(posedge clk); #1;
      chk("pre_mid_enc_q", 64'(if16.enc_q), 64'd11);
      #2 rst = 1'b1;
      #1;
      $display("mid-stream rst enc_q=%0d dec_q=%h any_q=%0d", if16.enc_q, if16.dec_q, if16.any_q);
      chk("mid_rst_enc_q", 64'(if16.enc_q), 64'd16);
      chk("mid_rst_dec_q", 64'(if16.dec_q), 64'h0);
      chk("mid_rst_any_q", 64'(if16.any_q), 64'd0);
      chk("mid_rst_enc_comb", 64'(if16.enc), 64'd11);
      @(negedge clk) rst = 1'b0;

      // Random stimulus, right-shifted by a random amount to spread the counts.
      for (int it = 0; it < 300; it++) begin
         @(negedge clk);
         r4  = 4'($urandom);
         r16 = 16'($urandom) >> $urandom_range(0, 16);
         for (int k = 0; k < 32; k++) r1k[k*32 +: 32] = $urandom;
         r1k = r1k >> $urandom_range(0, 1024);
         if4.a  = r4;
         if16.a = r16;
         if1k.a = r1k;
         n4  = ref_lz(1024'(r4), 4);
         n16 = ref_lz(1024'(r16), 16);
         n1k = ref_lz(r1k, 1024);
         d4  = ref_dec(1024'(r4), 4);
         d16 = ref_dec(1024'(r16), 16);
         d1k = ref_dec(r1k, 1024);
         #1;
         $display("rnd %0d a4=%h enc4=%0d a16=%h enc16=%0d enc1k=%0d", it, r4, if4.enc, r16, if16.enc, if1k.enc);
         chk("rnd_enc4", 64'(if4.enc), 64'(n4));
         chk("rnd_dec4", 64'(if4.dec), d4[63:0]);
         chk("rnd_any4", 64'(if4.any), (n4 < 4) ? 64'd1 : 64'd0);
         chk("rnd_enc16", 64'(if16.enc), 64'(n16));
         chk("rnd_dec16", 64'(if16.dec), d16[63:0]);
         chk("rnd_any16", 64'(if16.any), (n16 < 16) ? 64'd1 : 64'd0);
         chk("rnd_enc1k", 64'(if1k.enc), 64'(n1k));
         chk_wide("rnd_dec1k", if1k.dec, d1k);
         chk("rnd_any1k", 64'(if1k.any), (n1k < 1024) ? 64'd1 : 64'd0);
         @(posedge clk); #1;
         chk("rnd_enc_q4", 64'(if4.enc_q), 64'(n4));
         chk("rnd_dec_q4", 64'(if4.dec_q), d4[63:0]);
         chk("rnd_any_q4", 64'(if4.any_q), (n4 < 4) ? 64'd1 : 64'd0);
         chk("rnd_enc_q16", 64'(if16.enc_q), 64'(n16));
         chk("rnd_dec_q16", 64'(if16.dec_q), d16[63:0]);
         chk("rnd_any_q16", 64'(if16.any_q), (n16 < 16) ? 64'd1 : 64'd0);
         chk("rnd_enc_q1k", 64'(if1k.enc_q), 64'(n1k));
         chk_wide("rnd_dec_q1k", if1k.dec_q, d1k);
         chk("rnd_any_q1k", 64'(if1k.any_q), (n1k < 1024) ? 64'd1 : 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
